// File: rtl/ber_pkg.sv
// ber_pkg: shared state type, latency width and saturating counter helper for the BER monitor
package ber_pkg;
  typedef enum logic {SEARCH, LOCKED} state_t;

  function automatic int lat_w(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v >= max) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/ber_ref_history.sv
// ber_ref_history: reference bit history, fill count and candidate tap read
module ber_ref_history import ber_pkg::*; #(
  parameter int MAX_LAT = 64,
  localparam int CW = $clog2(MAX_LAT),
  localparam int LW = lat_w(MAX_LAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ref_i,
  input  logic          ref_valid_i,
  input  logic [CW-1:0] c,
  output logic          hist_bit,
  output logic          avail
);
  logic [MAX_LAT-1:0] hist;
  logic [LW-1:0]      fill;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (ref_valid_i) begin
      hist <= {hist[MAX_LAT-2:0], ref_i};
      fill <= (fill == LW'(MAX_LAT)) ? fill : fill + LW'(1);
    end

  // reads are pre-shift, so a same-cycle ref event never disturbs the compare
  assign hist_bit = hist[c];
  assign avail    = fill > LW'(c);
endmodule

// File: rtl/ber_monitor.sv
// ber_monitor: automatic latency search, lock tracking and post-decoding bit/error counting
module ber_monitor import ber_pkg::*; #(
  parameter int MAX_LAT  = 64,
  parameter int WIN      = 32,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ref_i,
  input  logic                       ref_valid_i,
  input  logic                       dec_i,
  input  logic                       dec_valid_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [lat_w(MAX_LAT)-1:0]  latency_o,
  output logic [CNT_W-1:0]           bit_ct_o,
  output logic [CNT_W-1:0]           err_ct_o,
  output logic                       sync_loss_o
);
  localparam int CW = $clog2(MAX_LAT);
  localparam int LW = lat_w(MAX_LAT);
  localparam int RW = $clog2(WIN + 1);
  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(LOSS_THR + 1);
  localparam logic [63:0] CNT_MAX = 64'((65'd1 << CNT_W) - 65'd1);

  state_t        state;
  logic [CW-1:0] c;
  logic [RW-1:0] run;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  logic          hist_bit, avail, mm;
  logic [63:0]   bit_nx, err_nx;

  ber_ref_history #(.MAX_LAT(MAX_LAT)) u_hist (
    .clk(clk), .rst(rst), .ref_i(ref_i), .ref_valid_i(ref_valid_i),
    .c(c), .hist_bit(hist_bit), .avail(avail)
  );

  assign mm       = dec_i ^ hist_bit;
  assign bit_nx   = sat_inc(64'(bit_ct_o), CNT_MAX);
  assign err_nx   = sat_inc(64'(err_ct_o), CNT_MAX);
  assign locked_o = state == LOCKED;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= SEARCH;
      c           <= '0;
      run         <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      latency_o   <= '0;
      bit_ct_o    <= '0;
      err_ct_o    <= '0;
      sync_loss_o <= 1'b0;
    end else begin
      sync_loss_o <= 1'b0;
      if (dec_valid_i && state == SEARCH && avail) begin
        if (mm) begin
          run <= '0;
          c   <= (c == CW'(MAX_LAT - 1)) ? '0 : c + CW'(1);
        end else if (run == RW'(WIN - 1)) begin
          state     <= LOCKED;
          latency_o <= LW'(c) + LW'(1);
          run       <= '0;
          win_cnt   <= '0;
          win_err   <= '0;
        end else
          run <= run + RW'(1);
      end
      if (dec_valid_i && state == LOCKED) begin
        bit_ct_o <= bit_nx[CNT_W-1:0];
        if (mm) err_ct_o <= err_nx[CNT_W-1:0];
        // c is left alone on loss so the previous latency is retried first
        if (mm && win_err == EW'(LOSS_THR - 1)) begin
          state       <= SEARCH;
          sync_loss_o <= 1'b1;
          run         <= '0;
          win_cnt     <= '0;
          win_err     <= '0;
        end else if (win_cnt == WW'(WIN - 1)) begin
          win_cnt <= '0;
          win_err <= '0;
        end else begin
          win_cnt <= win_cnt + WW'(1);
          win_err <= win_err + EW'(mm);
        end
      end
      if (clear_i) begin
        bit_ct_o <= '0;
        err_ct_o <= '0;
      end
    end
endmodule

// File: tb/tb_ber_monitor.sv
// tb_ber_monitor: randomized PRBS stimulus checked every cycle against a queue-based reference model
module tb_ber_monitor;
  localparam int MAX_LAT = 64, WIN = 32, LOSS_THR = 8;

  logic clk = 0, rst = 1, ref_i = 0, ref_valid_i = 0, dec_i = 0, dec_valid_i = 0, clear_i = 0;
  logic locked, locked4, sl, sl4;
  logic [6:0] lat, lat4;
  logic [31:0] bc, ec;
  logic [3:0] bc4, ec4;

  int checks = 0, failures = 0, loss_pulses = 0;

  always #5 clk = ~clk;

  ber_monitor dut (
    .clk(clk), .rst(rst), .ref_i(ref_i), .ref_valid_i(ref_valid_i), .dec_i(dec_i),
    .dec_valid_i(dec_valid_i), .clear_i(clear_i), .locked_o(locked), .latency_o(lat),
    .bit_ct_o(bc), .err_ct_o(ec), .sync_loss_o(sl)
  );

  ber_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ref_i(ref_i), .ref_valid_i(ref_valid_i), .dec_i(dec_i),
    .dec_valid_i(dec_valid_i), .clear_i(clear_i), .locked_o(locked4), .latency_o(lat4),
    .bit_ct_o(bc4), .err_ct_o(ec4), .sync_loss_o(sl4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input longint v, input int w);
    longint lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // reference model: q[k] is the ref bit from k+1 ref events ago
  bit q[$];
  bit m_lock, m_loss;
  int m_c, m_run, m_wcnt, m_werr, m_lat;
  longint m_bits, m_errs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_lock = 0; m_loss = 0; m_c = 0; m_run = 0; m_wcnt = 0; m_werr = 0; m_lat = 0;
      m_bits = 0; m_errs = 0;
    end else begin
      m_loss = 0;
      if (dec_valid_i) begin
        if (!m_lock) begin
          if (q.size() > m_c) begin
            if (dec_i == q[m_c]) begin
              m_run++;
              if (m_run == WIN) begin
                m_lock = 1; m_lat = m_c + 1; m_run = 0; m_wcnt = 0; m_werr = 0;
              end
            end else begin
              m_run = 0;
              m_c = (m_c + 1) % MAX_LAT;
            end
          end
        end else begin
          m_bits++;
          if (dec_i != q[m_c]) begin m_errs++; m_werr++; end
          if (m_werr == LOSS_THR) begin
            m_lock = 0; m_loss = 1; m_run = 0; m_wcnt = 0; m_werr = 0;
          end else begin
            m_wcnt++;
            if (m_wcnt == WIN) begin m_wcnt = 0; m_werr = 0; end
          end
        end
      end
      if (clear_i) begin m_bits = 0; m_errs = 0; end
      if (ref_valid_i) begin
        q.push_front(ref_i);
        if (q.size() > MAX_LAT) void'(q.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    check("locked", locked, m_lock);
    check("latency", lat, m_lat);
    check("bit_ct", bc, sat(m_bits, 32));
    check("err_ct", ec, sat(m_errs, 32));
    check("sync_loss", sl, m_loss);
    check("locked4", locked4, m_lock);
    check("latency4", lat4, m_lat);
    check("bit_ct4", bc4, sat(m_bits, 4));
    check("err_ct4", ec4, sat(m_errs, 4));
    check("sync_loss4", sl4, m_loss);
    if (sl) loss_pulses++;
  end

  bit src[$];
  int dly;
  logic [6:0] prbs;

  // one event: drive at a negedge, return at the following negedge with outputs updated
  task automatic step(input bit flip, input bit clr, input bit stall);
    int idx;
    bit nb;
    if (stall) begin
      ref_valid_i = 0;
      dec_valid_i = 0;
    end else begin
      nb = prbs[6] ^ prbs[5];
      prbs = {prbs[5:0], nb};
      src.push_back(nb);
      ref_i = nb;
      ref_valid_i = 1;
      idx = src.size() - 1 - dly;
      dec_valid_i = idx >= 0;
      dec_i = (idx >= 0 ? src[idx] : 1'b0) ^ flip;
    end
    clear_i = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_lock(input int max, input string name);
    for (int i = 0; i < max && !locked; i++) step(0, 0, 0);
    check(name, locked, 1);
  endtask

  task automatic wait_unlock(input int max, input string name);
    for (int i = 0; i < max && locked; i++) step(0, 0, 0);
    check(name, locked, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int loss0;
    prbs = 7'($urandom_range(1, 127));
    dly = 10;
    repeat (2) @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_latency", lat, 0);
    check("rst_bit_ct", bc, 0);
    check("rst_err_ct", ec, 0);
    rst = 0;

    wait_lock(2000, "t1_lock_timeout");
    check("t1_latency", lat, 10);
    step(0, 1, 0);
    check("t1_clear_prio", bc, 0);
    repeat (100) step(0, 0, 0);
    check("t1_bit_ct", bc, 100);
    check("t1_err_ct", ec, 0);
    check("t5_bit_ct4_sat", bc4, 15);
    step(0, 1, 0);
    check("t5_clear_bit_ct4", bc4, 0);
    check("t5_clear_bit_ct", bc, 0);

    loss0 = loss_pulses;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      repeat (39) step(0, 0, 0);
    end
    check("t2_err_ct", ec, 3);
    check("t2_locked", locked, 1);
    check("t2_no_loss", loss_pulses, loss0);

    for (int i = 0; i < WIN && m_wcnt != 0; i++) step(0, 0, 0);
    repeat (8) step(1, 0, 0);
    check("t3_unlocked", locked, 0);
    check("t3_pulse", sl, 1);
    check("t3_err_ct", ec, 11);
    step(0, 0, 0);
    check("t3_pulse_end", sl, 0);
    repeat (30) step(0, 0, 0);
    check("t3_not_yet", locked, 0);
    step(0, 0, 0);
    check("t3_relock", locked, 1);
    check("t3_latency", lat, 10);
    check("t3_err_kept", ec, 11);

    dly = 20;
    wait_unlock(300, "t4_loss_timeout");
    wait_lock(3000, "t4_lock_timeout");
    check("t4_latency", lat, 20);
    dly = 5;
    wait_unlock(300, "t4_wrap_loss_timeout");
    wait_lock(6000, "t4_wrap_lock_timeout");
    check("t4_wrap_latency", lat, 5);

    repeat (600) step($urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0);

    wait_lock(6000, "t6_prelock_timeout");
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("t6_locked", locked, 0);
    check("t6_latency", lat, 0);
    check("t6_bit_ct", bc, 0);
    check("t6_err_ct", ec, 0);
    check("t6_sync_loss", sl, 0);
    @(negedge clk);
    rst = 0;
    wait_lock(6000, "t6_relock_timeout");
    check("t6_latency_relock", lat, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ber_monitor.md
Name: ber_monitor

Overview:
Bit-error-rate monitor that sits directly downstream of the Viterbi decoder in the tx/rx harness. It keeps a history of the source bits fed to the convolutional encoder and finds the decoder's output latency automatically. Once aligned, it counts decoded bits and residual bit errors, so channel error-injection experiments report post-decoding BER without manual delay tuning.

Parameters:
MAX_LAT, 64, depth of the reference history; the largest decoder latency that can be searched, in ref-valid events
WIN, 32, compare window length, used both for lock qualification and for loss detection
LOSS_THR, 8, number of mismatches within one window that forces loss of lock
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
ref_i  in  1  source bit, the same bit presented to the encoder
ref_valid_i  in  1  ref_i is valid this cycle; shifts the history
dec_i  in  1  decoded bit from the Viterbi decoder
dec_valid_i  in  1  dec_i is valid this cycle; triggers one compare
clear_i  in  1  synchronous clear of the statistics counters only
locked_o  out  1  high while in LOCKED
latency_o  out  $clog2(MAX_LAT+1)  acquired latency; valid while locked_o is high
bit_ct_o  out  CNT_W  compares made while LOCKED (saturating)
err_ct_o  out  CNT_W  mismatches counted while LOCKED (saturating)
sync_loss_o  out  1  one-cycle pulse on each LOCKED-to-SEARCH transition

Behaviour:
- Reset (asynchronous): all outputs 0, history 0, fill count 0, candidate c=0, state SEARCH. Reset takes effect immediately at any point, including mid-lock.
- History: hist[0] receives ref_i on ref_valid_i and hist[k] receives hist[k-1]. At cycle t, hist[k] holds the ref bit from k+1 ref-valid events earlier.
- Fill count saturates at MAX_LAT.
- When ref_valid_i and dec_valid_i are high in the same cycle, the compare uses the pre-shift history.
- Compare: on dec_valid_i, mismatch = dec_i XOR hist[c]. Latency is c+1.
- States: SEARCH, LOCKED. The state type is a two-value enum.
- SEARCH:
  - A compare is made only if fill count > c; otherwise the cycle is ignored.
  - Match: run count +1. Mismatch: run count 0, and c = c+1, wrapping from MAX_LAT-1 to 0.
  - When run count reaches WIN: go to LOCKED; latency_o = c+1; the window counters clear.
  - Counters do not change in SEARCH.
- LOCKED:
  - Each compare increments bit_ct_o; each mismatch increments err_ct_o and win_err.
  - win_cnt counts compares 0..WIN-1. At the compare where win_cnt = WIN-1, win_cnt and win_err clear after that compare is evaluated.
  - When win_err reaches LOSS_THR, evaluated on the mismatch that reaches it: go to SEARCH the next cycle. The mismatch is still counted. sync_loss_o pulses, locked_o falls, run count resets to 0, and c keeps its current value so the old latency is retried first.
- latency_o holds its last value after loss of lock and is qualified by locked_o.
- Output timing: locked_o, latency_o, the counters and sync_loss_o are all registered. They are updated in the cycle after the deciding compare.
- Saturation: counters stick at all-ones; err_ct_o ≤ bit_ct_o always.
- clear_i:
  - Zeroes bit_ct_o and err_ct_o next cycle. It does not affect state, c or the window counters.
  - It has priority over a same-cycle increment (result 0).
- Constant-data streams can lock at any candidate. This is accepted; the bench must use PRBS stimulus.

Decomposition:
- Package ber_pkg holds:
  - typedef enum of the state {SEARCH, LOCKED}
  - localparam/function for the latency width, $clog2(MAX_LAT+1)
  - a saturating-increment function shared by both counters
- One sub-module, ber_ref_history: the MAX_LAT shift register, fill counter and hist[c] read mux. ber_monitor holds the FSM, window logic and counters.

Test Plan:
1. PRBS-7 on ref with ref_valid_i=1; dec_i = ref delayed 10 cycles with dec_valid_i=1 → locked_o rises; latency_o=10; after 100 further bits, bit_ct_o=100 and err_ct_o=0.
2. While locked, flip 3 dec bits spaced 40 compares apart → err_ct_o=3; locked_o stays high; sync_loss_o never pulses.
3. While locked, flip 8 dec bits within one 32-compare window → sync_loss_o single pulse; locked_o=0; after 32 clean compares, relock with latency_o=10 and counters retained.
4. Change the delay from 10 to 20 mid-stream → lock lost; relock with latency_o=20; candidate wraps correctly when searching past 63.
5. CNT_W=4, clean locked stream of 20 bits → bit_ct_o=15 and holds. Then clear_i in the same cycle as a compare → bit_ct_o=0 next cycle.
6. Assert rst mid-lock between clock edges → all outputs 0 immediately. After release, no compare occurs until the history fills past c, then the monitor reacquires.
